// File: rtl/sie_xact_ctrl.sv
// rtl/sie_xact_ctrl.sv - USB 2.0 host SIE transaction sequencer (token/data/handshake)
//
// Runs one OUT, IN or SETUP transaction per accepted xact_start. It keeps a
// per-endpoint data-toggle table, enforces the bus turnaround timeout and
// retries errored transactions automatically.
//
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   xact_start/type/addr/ep   transaction request from the schedule logic
//   toggle_clr           per-endpoint toggle reset to DATA0 (clear beats flip)
//   xact_busy/done/status/retry_cnt   transaction progress and result
//   tok_valid/tok_pid, data_send, data_toggle, hs_send   encoder requests
//   enc_done             encoder: requested packet fully transmitted
//   rx_active, rx_hs_*, rx_data_*, rx_crc_err   decoder events
//   data_discard         one-cycle pulse telling the rx FIFO to drop the payload
//
// Optional build macro SIE_XACT_ERR_CNT_EN adds err_count[7:0], a saturating
// count of timeout, CRC and corrupt-handshake events.
module sie_xact_ctrl #(
    parameter int NUM_EP      = 4,
    parameter int TIMEOUT_CYC = 24,
    parameter int MAX_RETRY   = 3,
    localparam int EPW        = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              xact_start,
    input  logic [1:0]        xact_type,
    input  logic [6:0]        xact_addr,
    input  logic [EPW-1:0]    xact_ep,
    input  logic [NUM_EP-1:0] toggle_clr,
    output logic              xact_busy,
    output logic              xact_done,
    output logic [2:0]        xact_status,
    output logic [2:0]        retry_cnt,
    output logic              tok_valid,
    output logic [3:0]        tok_pid,
    output logic              data_send,
    output logic              data_toggle,
    output logic              hs_send,
    input  logic              enc_done,
    input  logic              rx_active,
    input  logic              rx_hs_valid,
    input  logic [3:0]        rx_hs_pid,
    input  logic              rx_hs_corrupt,
    input  logic              rx_data_valid,
    input  logic              rx_data_pid1,
    input  logic              rx_crc_err,
`ifdef SIE_XACT_ERR_CNT_EN
    output logic [7:0]        err_count,
`endif
    output logic              data_discard
);

    localparam int TOW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TOW-1:0] TO_LAST   = TOW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]     MAX_R     = 3'(MAX_RETRY);

    localparam logic [1:0] T_OUT   = 2'd0;
    localparam logic [1:0] T_IN    = 2'd1;
    localparam logic [1:0] T_SETUP = 2'd2;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    localparam logic [2:0] ST_ACK     = 3'd0;
    localparam logic [2:0] ST_NAK     = 3'd1;
    localparam logic [2:0] ST_STALL   = 3'd2;
    localparam logic [2:0] ST_TIMEOUT = 3'd3;
    localparam logic [2:0] ST_CRC     = 3'd4;
    localparam logic [2:0] ST_TOGGLE  = 3'd5;
    localparam logic [2:0] ST_PROTO   = 3'd6;

    typedef enum logic [2:0] {
        IDLE, TOKEN, DATA_TX, WAIT_HS, WAIT_DATA, SEND_ACK, DONE
    } state_t;

    state_t state, next_state;

    logic [1:0]        type_q;
    logic [6:0]        addr_q;
    logic [EPW-1:0]    ep_q;
    logic [2:0]        retry_q;
    logic [2:0]        status_q;
    logic [NUM_EP-1:0] toggle_tbl;
    logic [TOW-1:0]    to_cnt;
    logic              to_frozen;
    logic              discard_q;

    logic       cur_tog;
    logic       is_setup;
    logic       in_wait;
    logic       timeout;
    logic       status_wr;
    logic [2:0] status_nxt;
    logic       retry_req;
    logic [2:0] retry_cause;
    logic       retry_inc;
    logic       tog_wr;
    logic       tog_val;
    logic       discard_nxt;
    logic       err_evt;

    // The address is held as transaction context; nothing in this block reads it.
    logic unused_addr;
    assign unused_addr = ^addr_q;

    assign cur_tog  = toggle_tbl[ep_q];
    assign is_setup = (type_q == T_SETUP);
    assign in_wait  = (state == WAIT_HS) || (state == WAIT_DATA);
    // Once the device starts answering, the turnaround window is over for good.
    assign timeout  = in_wait && !to_frozen && !rx_active && (to_cnt == TO_LAST);

    assign xact_status  = status_q;
    assign retry_cnt    = retry_q;
    assign data_discard = discard_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        xact_busy   = 1'b0;
        xact_done   = 1'b0;
        tok_valid   = 1'b0;
        tok_pid     = 4'h0;
        data_send   = 1'b0;
        data_toggle = 1'b0;
        hs_send     = 1'b0;
        status_wr   = 1'b0;
        status_nxt  = ST_ACK;
        retry_req   = 1'b0;
        retry_cause = ST_TIMEOUT;
        retry_inc   = 1'b0;
        tog_wr      = 1'b0;
        tog_val     = 1'b0;
        discard_nxt = 1'b0;
        err_evt     = 1'b0;

        case (state)
            IDLE: begin
                if (xact_start) next_state = TOKEN;
            end
            TOKEN: begin
                xact_busy = 1'b1;
                tok_valid = 1'b1;
                case (type_q)
                    T_IN:    tok_pid = PID_IN;
                    T_SETUP: tok_pid = PID_SETUP;
                    default: tok_pid = PID_OUT;
                endcase
                if (enc_done) next_state = (type_q == T_IN) ? WAIT_DATA : DATA_TX;
            end
            DATA_TX: begin
                xact_busy   = 1'b1;
                data_send   = 1'b1;
                data_toggle = is_setup ? 1'b0 : cur_tog;
                if (enc_done) next_state = WAIT_HS;
            end
            WAIT_HS: begin
                xact_busy = 1'b1;
                // Decoder pulses are checked before the timeout so they win a tie.
                if (rx_hs_valid) begin
                    next_state = DONE;
                    status_wr  = 1'b1;
                    case (rx_hs_pid)
                        PID_ACK: begin
                            status_nxt = ST_ACK;
                            tog_wr     = 1'b1;
                            // SETUP always leaves the endpoint expecting DATA1 next.
                            tog_val    = is_setup ? 1'b1 : ~cur_tog;
                        end
                        PID_NAK:   status_nxt = ST_NAK;
                        PID_STALL: status_nxt = ST_STALL;
                        default:   status_nxt = ST_PROTO;
                    endcase
                end else if (rx_hs_corrupt) begin
                    retry_req   = 1'b1;
                    retry_cause = ST_CRC;
                end else if (timeout) begin
                    retry_req   = 1'b1;
                    retry_cause = ST_TIMEOUT;
                end
            end
            WAIT_DATA: begin
                xact_busy   = 1'b1;
                data_toggle = cur_tog;
                if (rx_data_valid) begin
                    next_state = SEND_ACK;
                    status_wr  = 1'b1;
                    if (rx_data_pid1 == cur_tog) begin
                        status_nxt = ST_ACK;
                        tog_wr     = 1'b1;
                        tog_val    = ~cur_tog;
                    end else begin
                        // Duplicate of a packet already taken: ACK it but drop it.
                        status_nxt  = ST_TOGGLE;
                        discard_nxt = 1'b1;
                    end
                end else if (rx_crc_err) begin
                    discard_nxt = 1'b1;
                    retry_req   = 1'b1;
                    retry_cause = ST_CRC;
                end else if (rx_hs_valid) begin
                    next_state = DONE;
                    status_wr  = 1'b1;
                    case (rx_hs_pid)
                        PID_NAK:   status_nxt = ST_NAK;
                        PID_STALL: status_nxt = ST_STALL;
                        default:   status_nxt = ST_PROTO;
                    endcase
                end else if (rx_hs_corrupt) begin
                    retry_req   = 1'b1;
                    retry_cause = ST_CRC;
                end else if (timeout) begin
                    retry_req   = 1'b1;
                    retry_cause = ST_TIMEOUT;
                end
            end
            SEND_ACK: begin
                xact_busy = 1'b1;
                hs_send   = 1'b1;
                if (enc_done) next_state = DONE;
            end
            DONE: begin
                xact_done  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        if (retry_req) begin
            err_evt = 1'b1;
            if (retry_q < MAX_R) begin
                retry_inc  = 1'b1;
                next_state = TOKEN;
            end else begin
                next_state = DONE;
                status_wr  = 1'b1;
                status_nxt = retry_cause;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            type_q     <= T_OUT;
            addr_q     <= '0;
            ep_q       <= '0;
            retry_q    <= '0;
            status_q   <= '0;
            toggle_tbl <= '0;
            to_cnt     <= '0;
            to_frozen  <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            if (state == IDLE && xact_start) begin
                type_q   <= (xact_type == 2'd3) ? T_OUT : xact_type;
                addr_q   <= xact_addr;
                ep_q     <= xact_ep;
                retry_q  <= '0;
                status_q <= '0;
            end
            if (retry_inc) retry_q <= retry_q + 3'd1;
            if (status_wr) status_q <= status_nxt;
            discard_q <= discard_nxt;

            // Counter is idle outside the wait states, so every entry starts at 0.
            if (!in_wait) begin
                to_cnt    <= '0;
                to_frozen <= 1'b0;
            end else if (!to_frozen) begin
                if (rx_active) to_frozen <= 1'b1;
                else           to_cnt    <= to_cnt + TOW'(1);
            end

            for (int i = 0; i < NUM_EP; i++) begin
                if (toggle_clr[i])                       toggle_tbl[i] <= 1'b0;
                else if (tog_wr && ep_q == EPW'(i))      toggle_tbl[i] <= tog_val;
            end
        end
    end

`ifdef SIE_XACT_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_count <= 8'd0;
        end else if (err_evt && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sie_xact_ctrl.sv
// tb/tb_sie_xact_ctrl.sv - directed self-checking bench for sie_xact_ctrl
module tb_sie_xact_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       xact_start;
    logic [1:0] xact_type;
    logic [6:0] xact_addr;
    logic [1:0] xact_ep;
    logic [3:0] toggle_clr;
    logic       xact_busy;
    logic       xact_done;
    logic [2:0] xact_status;
    logic [2:0] retry_cnt;
    logic       tok_valid;
    logic [3:0] tok_pid;
    logic       data_send;
    logic       data_toggle;
    logic       hs_send;
    logic       enc_done;
    logic       rx_active;
    logic       rx_hs_valid;
    logic [3:0] rx_hs_pid;
    logic       rx_hs_corrupt;
    logic       rx_data_valid;
    logic       rx_data_pid1;
    logic       rx_crc_err;
    logic       data_discard;
`ifdef SIE_XACT_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    sie_xact_ctrl #(.NUM_EP(4), .TIMEOUT_CYC(24), .MAX_RETRY(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .xact_start    (xact_start),
        .xact_type     (xact_type),
        .xact_addr     (xact_addr),
        .xact_ep       (xact_ep),
        .toggle_clr    (toggle_clr),
        .xact_busy     (xact_busy),
        .xact_done     (xact_done),
        .xact_status   (xact_status),
        .retry_cnt     (retry_cnt),
        .tok_valid     (tok_valid),
        .tok_pid       (tok_pid),
        .data_send     (data_send),
        .data_toggle   (data_toggle),
        .hs_send       (hs_send),
        .enc_done      (enc_done),
        .rx_active     (rx_active),
        .rx_hs_valid   (rx_hs_valid),
        .rx_hs_pid     (rx_hs_pid),
        .rx_hs_corrupt (rx_hs_corrupt),
        .rx_data_valid (rx_data_valid),
        .rx_data_pid1  (rx_data_pid1),
        .rx_crc_err    (rx_crc_err),
`ifdef SIE_XACT_ERR_CNT_EN
        .err_count     (err_count),
`endif
        .data_discard  (data_discard)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_xact(input logic [1:0] t, input logic [1:0] ep);
        xact_type  = t;
        xact_ep    = ep;
        xact_addr  = 7'h15;
        xact_start = 1'b1;
        step;
        xact_start = 1'b0;
    endtask

    task automatic enc_pulse;
        enc_done = 1'b1;
        step;
        enc_done = 1'b0;
    endtask

    task automatic hs(input logic [3:0] pid);
        rx_hs_valid = 1'b1;
        rx_hs_pid   = pid;
        step;
        rx_hs_valid = 1'b0;
    endtask

    task automatic data_in(input logic pid1);
        rx_data_valid = 1'b1;
        rx_data_pid1  = pid1;
        step;
        rx_data_valid = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b0; xact_start = 1'b0; xact_type = 2'd0; xact_addr = 7'd0; xact_ep = 2'd0;
        toggle_clr = 4'd0; enc_done = 1'b0; rx_active = 1'b0; rx_hs_valid = 1'b0;
        rx_hs_pid = 4'd0; rx_hs_corrupt = 1'b0; rx_data_valid = 1'b0; rx_data_pid1 = 1'b0;
        rx_crc_err = 1'b0;
        step; step;
        chk("rst_busy", xact_busy, 0);
        chk("rst_done", xact_done, 0);
        chk("rst_tok", {tok_valid, tok_pid}, 0);
        chk("rst_send", {data_send, hs_send, data_discard}, 0);
        chk("rst_status", {xact_status, retry_cnt}, 0);
        reset = 1'b1;
        step;

        // OUT ep1, toggle 0, ACK
        start_xact(2'd0, 2'd1);
        chk("out_busy", xact_busy, 1);
        chk("out_tok", {tok_valid, tok_pid}, 5'h11);
        enc_pulse;
        chk("out_send", data_send, 1);
        chk("out_tog0", data_toggle, 0);
        enc_pulse;
        hs(4'h2);
        chk("out_done", {xact_done, xact_busy}, 2'b10);
        chk("out_status", xact_status, 0);
        chk("out_retry", retry_cnt, 0);
        step;
        chk("out_idle", {xact_done, xact_busy}, 0);

        // OUT ep1 again: table[1] is now 1; NAK leaves it alone
        start_xact(2'd0, 2'd1);
        enc_pulse;
        chk("out2_tog1", data_toggle, 1);
        enc_pulse;
        hs(4'hA);
        chk("out2_nak", xact_status, 1);
        step;

        // IN ep2 DATA0 good
        start_xact(2'd1, 2'd2);
        chk("in_pid", tok_pid, 4'h9);
        enc_pulse;
        chk("in_exp_tog", data_toggle, 0);
        data_in(1'b0);
        chk("in_hs_send", hs_send, 1);
        chk("in_no_discard", data_discard, 0);
        enc_pulse;
        chk("in_done", xact_done, 1);
        chk("in_status", xact_status, 0);
        step;

        // IN ep2 DATA0 again: toggle mismatch
        start_xact(2'd1, 2'd2);
        enc_pulse;
        chk("in2_exp_tog", data_toggle, 1);
        data_in(1'b0);
        chk("in2_discard", data_discard, 1);
        chk("in2_hs_send", hs_send, 1);
        enc_pulse;
        chk("in2_discard_end", data_discard, 0);
        chk("in2_status", {xact_done, xact_status}, 4'hD);
        step;

        // OUT ep0 ACK sets table[0]=1, then SETUP ep0 sends DATA0
        start_xact(2'd0, 2'd0);
        enc_pulse; enc_pulse; hs(4'h2); step;
        start_xact(2'd2, 2'd0);
        chk("setup_pid", tok_pid, 4'hD);
        enc_pulse;
        chk("setup_tog0", data_toggle, 0);
        enc_pulse;
        hs(4'h2);
        chk("setup_status", xact_status, 0);
        step;
        // table[0] is 1 after SETUP; ACK with toggle_clr[0] in the same cycle clears it
        start_xact(2'd0, 2'd0);
        enc_pulse;
        chk("post_setup_tog1", data_toggle, 1);
        enc_pulse;
        toggle_clr = 4'b0001;
        hs(4'h2);
        toggle_clr = 4'b0000;
        step;

        // IN ep0 with no device response: 4 tokens, 24 silent cycles each
        start_xact(2'd1, 2'd0);
        for (int a = 0; a < 4; a++) begin
            chk("to_token", tok_valid, 1);
            enc_pulse;
            if (a == 0) chk("clr_wins_tog0", data_toggle, 0);
            n = 0;
            while (!tok_valid && !xact_done && n < 100) begin
                step;
                n++;
            end
            chk("to_wait_cycles", n, 24);
            if (a < 3) chk("to_retry_cnt", retry_cnt, a + 1);
        end
        chk("to_done", xact_done, 1);
        chk("to_status", xact_status, 3);
        chk("to_retry_final", retry_cnt, 3);
        step;

        // OUT ep1 (table[1]=1): corrupt handshake, retry, ACK on last timeout cycle
        start_xact(2'd0, 2'd1);
        enc_pulse;
        chk("cor_tog", data_toggle, 1);
        enc_pulse;
        rx_hs_corrupt = 1'b1;
        step;
        rx_hs_corrupt = 1'b0;
        chk("cor_retoken", tok_valid, 1);
        chk("cor_retry", retry_cnt, 1);
        enc_pulse;
        chk("cor_tog_same", data_toggle, 1);
        enc_pulse;
        for (int k = 0; k < 23; k++) step;
        chk("cor_still_wait", {tok_valid, xact_done, xact_busy}, 3'b001);
        hs(4'h2);
        chk("cor_done", xact_done, 1);
        chk("cor_status", {xact_status, retry_cnt}, 6'o01);
        step;

        // OUT ep1: single flip gave 0; start while busy ignored; STALL
        start_xact(2'd0, 2'd1);
        enc_pulse;
        chk("flip_once_tog0", data_toggle, 0);
        enc_pulse;
        xact_type = 2'd1;
        xact_start = 1'b1;
        step;
        xact_start = 1'b0;
        hs(4'hE);
        chk("stall_status", xact_status, 2);
        step;
        chk("busy_start_ignored", {xact_busy, tok_valid}, 0);

        // IN ep3: CRC error discards and retries, then NAK
        start_xact(2'd1, 2'd3);
        enc_pulse;
        rx_crc_err = 1'b1;
        step;
        rx_crc_err = 1'b0;
        chk("crc_discard", data_discard, 1);
        chk("crc_retoken", {tok_valid, retry_cnt}, 4'h9);
        chk("crc_no_hs", hs_send, 0);
        enc_pulse;
        hs(4'hA);
        chk("in_nak", {xact_done, xact_status}, 4'h9);
        step;

        // Reset mid-transaction in WAIT_DATA on ep2 (table[2] stayed 1)
        start_xact(2'd1, 2'd2);
        enc_pulse;
        chk("mid_tog1", data_toggle, 1);
        reset = 1'b0;
        step;
        chk("mid_rst_out", {xact_busy, xact_done, tok_valid, data_send, hs_send, data_toggle}, 0);
        chk("mid_rst_status", {xact_status, retry_cnt, data_discard}, 0);
        reset = 1'b1;
        step;
        chk("mid_no_done", xact_done, 0);
        start_xact(2'd1, 2'd2);
        enc_pulse;
        chk("mid_tbl_clr", data_toggle, 0);
        hs(4'hA);
        chk("mid_nak", xact_status, 1);
        step;
        start_xact(2'd1, 2'd2);
        enc_pulse;
        chk("nak_no_flip", data_toggle, 0);
        hs(4'hA);
        step;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
